pe_window_feeder: RTL and testbench
===================================

# pe_window_feeder

Streaming front end for the PE. It accepts a raster pixel stream (IMG_H rows of IMG_W pixels) through a valid/ready handshake and latches one K-tap weight vector per frame. For each accepted pixel that completes a K-wide horizontal window within the current row, it emits that window, packed for the PE's `in_valid`/`in_data`/`weight` inputs. Padding is not supported: each row yields IMG_W-K+1 windows.

## Interface

- K, 3, window/tap count; must match the PE
- DATA_W, 8, signed pixel/weight width
- IMG_W, 32, pixels per row; requires IMG_W ≥ K
- IMG_H, 32, rows per frame

- clk  in  1  rising-edge clock (single clock domain)
- rst_n  in  1  asynchronous, active-low reset
- w_valid  in  1  weight vector offered
- w_data  in  K*DATA_W  weights; tap i at [i*DATA_W +: DATA_W]
- w_ready  out  1  feeder accepts weights (high only in IDLE)
- pix_valid  in  1  pixel offered
- pix_data  in  DATA_W  pixel value
- pix_last  in  1  marks the last pixel of a row
- pix_ready  out  1  feeder accepts pixels (high only in RUN)
- out_valid  out  1  window valid; drives PE `in_valid`
- out_data  out  K*DATA_W  window; element 0 = oldest (leftmost) pixel; drives PE `in_data`
- out_weight  out  K*DATA_W  latched weights; drives PE `weight`
- frame_done  out  1  one-cycle pulse at the end of a frame
- row_err  out  1  sticky flag for a `pix_last` position mismatch

## Operation

- **FSM:** two states, IDLE and RUN. Reset enters IDLE.
- **IDLE → RUN:** on `w_valid && w_ready`.
  - `w_data` is latched into `out_weight`.
  - `col`, `row` and `row_err` are cleared.
- **RUN → IDLE:** on acceptance of pixel (row = IMG_H-1, col = IMG_W-1).
- **Handshake outputs:** `w_ready = (state == IDLE)` and `pix_ready = (state == RUN)`. Both are derived from the registered state only and never depend on the `*_valid` inputs.
- **Pixel accept:** occurs when `pix_valid && pix_ready`.
  - The window shifts: `win[j] <= win[j+1]` for j < K-1, and `win[K-1] <= pix_data`.
  - `col` increments. At IMG_W-1 it wraps to 0 and `row` increments.
- **Window emit:** on an accept with pre-increment `col ≥ K-1`, the next cycle has `out_valid = 1` and `out_data` equal to the shifted window.
- **Row isolation:** windows never span rows. The col-based emit rule guarantees this; the shift register is not cleared between rows.
- **Row length:** the column counter is authoritative for row length.
  - `row_err` sets if `pix_last = 1` is accepted at col ≠ IMG_W-1.
  - `row_err` sets if `pix_last = 0` is accepted at col = IMG_W-1.
  - Once set, `row_err` holds until the next weight load or reset.
- **Weight stability:** `out_weight` is constant from the weight load until the next weight load, including across IDLE.

## Timing

- **Reset values:** `out_valid`=0, `out_data`=0, `out_weight`=0, `frame_done`=0, `row_err`=0, `w_ready`=1, `pix_ready`=0. Window, `col` and `row` are 0.
- **Latency:** 1 cycle from accepting the pixel that completes a window to `out_valid`.
- **Throughput:** 1 pixel per cycle. `out_valid` is high only in cycles following an emitting accept.
- **Hold behaviour:** on non-emitting cycles `out_data` holds its last value. Consumers qualify with `out_valid`.
- **frame_done:** asserts in the same cycle as the frame's final `out_valid`.
- **Pipeline with PE:** `partial_valid` follows `out_valid` by 2 cycles.
- **Return to IDLE:** `pix_ready` drops in the cycle after the final accept. `w_ready` rises in that same cycle.
- **Reset mid-frame:** all state clears immediately and the block returns to IDLE. No `out_valid` is produced from pre-reset pixels.
- **Weights during RUN:** `w_valid` in RUN is ignored because `w_ready = 0`.

## Structure

- **Shared package `pe_stream_pkg`:**
  - defaults for K and DATA_W, shared with the PE;
  - FSM state encodings `ST_IDLE` and `ST_RUN`;
  - a window-packing helper or width constants.
- **Sub-module `pe_win_shift`:** the K-entry DATA_W shift register with a shift-enable and a packed output.
- **Top level:** the FSM, `col`/`row` counters, weight register, emit/`frame_done`/`row_err` logic, and the `pe_win_shift` instance.

## Test plan

All scenarios use K=3, DATA_W=8, IMG_W=5, IMG_H=2.

- **Reset:** assert `rst_n` = 0 mid-run → next edge shows `w_ready`=1, `pix_ready`=0, `out_valid`=0, `row_err`=0, `out_weight`=0.
- **Single row:** load weights {1,2,3}, then stream 10,20,30,40,50 with `pix_last` on 50 → windows {10,20,30}, {20,30,40}, {30,40,50}. The first window appears 1 cycle after 30 is accepted, and `out_weight` = {1,2,3}.
- **Frame end:** stream row 2 as -1,-2,-3,-4,-5 → windows {-1,-2,-3}, {-2,-3,-4}, {-3,-4,-5}, with no window mixing 40/50 and -1. `frame_done` pulses once together with {-3,-4,-5}; afterwards `pix_ready`=0 and `w_ready`=1.
- **Stalls:** insert 2 idle cycles between every pixel → same three windows per row, with `out_valid` exactly 1 cycle after each emitting accept and low otherwise.
- **Bad `pix_last`:** `pix_last` on the 3rd pixel and missing on the 5th → `row_err`=1 from the cycle after the 3rd accept. Windows still follow column count, and the next weight load clears `row_err`.
- **Reset mid-row:** reset after 3 pixels → no `out_valid`. Reload weights {4,5,6} and stream 1..5 → windows {1,2,3}, {2,3,4}, {3,4,5}, with no stale data.

Source files
------------

// File: rtl/pe_stream_pkg.sv
// Shared definitions for the PE streaming path: default geometry, feeder FSM states, window width helper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: K_DEF / DATA_W_DEF defaults shared with the PE, state_t encodings, win_width().
package pe_stream_pkg;

   // Defaults shared with the PE; the PE and feeder must agree on both.
   localparam int K_DEF      = 3;
   localparam int DATA_W_DEF = 8;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   // Width of a packed K-element window (tap i at [i*data_w +: data_w]).
   function automatic int win_width(input int k, input int data_w);
      return k * data_w;
   endfunction

endpackage

// File: rtl/pe_window_feeder_if.sv
// Bundles the weight handshake, pixel handshake and PE-facing window outputs of the window feeder.
// Latency: n/a (wiring only).
// Backpressure: w_ready / pix_ready driven by the feeder (slave); the source (master) holds *_valid until accepted.
// Ports: w_valid/w_data/w_ready, pix_valid/pix_data/pix_last/pix_ready, out_valid/out_data/out_weight, frame_done, row_err.
interface pe_window_feeder_if
   import pe_stream_pkg::*;
#(
   parameter int K      = K_DEF,
   parameter int DATA_W = DATA_W_DEF
);
   localparam int WIN_W = win_width(K, DATA_W);

   logic              w_valid;
   logic [WIN_W-1:0]  w_data;
   logic              w_ready;
   logic              pix_valid;
   logic [DATA_W-1:0] pix_data;
   logic              pix_last;
   logic              pix_ready;
   logic              out_valid;
   logic [WIN_W-1:0]  out_data;
   logic [WIN_W-1:0]  out_weight;
   logic              frame_done;
   logic              row_err;

   // Source side: offers weights and pixels, observes the feeder outputs.
   modport master (
      output w_valid, w_data, pix_valid, pix_data, pix_last,
      input  w_ready, pix_ready, out_valid, out_data, out_weight, frame_done, row_err
   );

   // Feeder side.
   modport slave (
      input  w_valid, w_data, pix_valid, pix_data, pix_last,
      output w_ready, pix_ready, out_valid, out_data, out_weight, frame_done, row_err
   );

endinterface

// File: rtl/pe_win_shift.sv
// K-entry DATA_W shift register holding the current horizontal pixel window.
// Latency: 1 cycle from shift_en to the updated window on win_dat.
// Backpressure: none; shifts whenever shift_en is high.
// Ports: clk, rst_n, shift_en, din (newest pixel), win_dat (packed window, element 0 = oldest).
module pe_win_shift #(
   parameter int K      = 3,
   parameter int DATA_W = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  shift_en,
   input  logic [DATA_W-1:0]     din,
   output logic [K*DATA_W-1:0]   win_dat
);

   logic [K*DATA_W-1:0] win_q;

   // Oldest entry sits at the bottom; each shift drops it and appends din at the top.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         win_q <= '0;
      end else if (shift_en) begin
         for (int j = 0; j < K - 1; j++) begin
            win_q[j*DATA_W +: DATA_W] <= win_q[(j+1)*DATA_W +: DATA_W];
         end
         win_q[(K-1)*DATA_W +: DATA_W] <= din;
      end
   end

   assign win_dat = win_q;

endmodule

// File: rtl/pe_window_feeder.sv
// Turns a raster pixel stream into K-wide horizontal windows plus a per-frame weight vector for the PE.
// Latency: 1 cycle from the accept that completes a window to out_valid; 1 pixel/cycle throughput.
// Backpressure: w_ready only in IDLE, pix_ready only in RUN; neither depends on *_valid. Output side has none.
// Ports: clk, rst_n (async, active low), bus (slave modport: weight handshake, pixel handshake,
//        out_valid/out_data/out_weight to the PE, frame_done pulse, sticky row_err).
module pe_window_feeder
   import pe_stream_pkg::*;
#(
   parameter int K      = K_DEF,
   parameter int DATA_W = DATA_W_DEF,
   parameter int IMG_W  = 32,
   parameter int IMG_H  = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   pe_window_feeder_if.slave  bus
);

   localparam int WIN_W = win_width(K, DATA_W);
   localparam int CW    = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int RW    = (IMG_H > 1) ? $clog2(IMG_H) : 1;

   localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
   localparam logic [CW-1:0] COL_EMIT = CW'(K - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

   state_t            state;
   state_t            state_nxt;
   logic              w_ready;
   logic              pix_ready;
   logic              w_load;
   logic              pix_acc;
   logic              col_end;
   logic              row_end;
   logic              emit;

   logic [CW-1:0]     col_q;
   logic [RW-1:0]     row_q;
   logic [WIN_W-1:0]  weight_q;
   logic              out_valid_q;
   logic              frame_done_q;
   logic              row_err_q;
   logic [WIN_W-1:0]  hold_q;
   logic [WIN_W-1:0]  win_dat;

   // ---------------- FSM ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      w_ready   = 1'b0;
      pix_ready = 1'b0;
      case (state)
         ST_IDLE: begin
            w_ready = 1'b1;
            if (bus.w_valid) begin
               state_nxt = ST_RUN;
            end
         end
         ST_RUN: begin
            pix_ready = 1'b1;
            if (bus.pix_valid && col_end && row_end) begin
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   assign w_load  = bus.w_valid && w_ready;
   assign pix_acc = bus.pix_valid && pix_ready;
   assign col_end = (col_q == COL_LAST);
   assign row_end = (row_q == ROW_LAST);
   // Column gating alone keeps windows inside a row: the first K-1 pixels of
   // every row only prime the shift register, flushing the previous row out.
   assign emit    = pix_acc && (col_q >= COL_EMIT);

   // ---------------- position counters ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col_q <= '0;
         row_q <= '0;
      end else if (w_load) begin
         col_q <= '0;
         row_q <= '0;
      end else if (pix_acc) begin
         if (col_end) begin
            col_q <= '0;
            row_q <= row_end ? '0 : row_q + RW'(1);
         end else begin
            col_q <= col_q + CW'(1);
         end
      end
   end

   // ---------------- weights, status, output registers ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         weight_q     <= '0;
         out_valid_q  <= 1'b0;
         frame_done_q <= 1'b0;
         row_err_q    <= 1'b0;
      end else begin
         if (w_load) begin
            weight_q <= bus.w_data;
         end
         out_valid_q  <= emit;
         // The last pixel of the frame always completes a window, so this
         // pulse coincides with the final out_valid.
         frame_done_q <= pix_acc && col_end && row_end;
         // The column counter decides row length; pix_last is only audited.
         if (w_load) begin
            row_err_q <= 1'b0;
         end else if (pix_acc && (bus.pix_last != col_end)) begin
            row_err_q <= 1'b1;
         end
      end
   end

   // The shift register keeps moving on non-emitting accepts (row priming),
   // so the last emitted window is captured here to keep out_data stable.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_q <= '0;
      end else if (out_valid_q) begin
         hold_q <= win_dat;
      end
   end

   pe_win_shift #(
      .K      (K),
      .DATA_W (DATA_W)
   ) u_win_shift (
      .clk      (clk),
      .rst_n    (rst_n),
      .shift_en (pix_acc),
      .din      (bus.pix_data),
      .win_dat  (win_dat)
   );

   assign bus.w_ready    = w_ready;
   assign bus.pix_ready  = pix_ready;
   assign bus.out_valid  = out_valid_q;
   assign bus.out_data   = out_valid_q ? win_dat : hold_q;
   assign bus.out_weight = weight_q;
   assign bus.frame_done = frame_done_q;
   assign bus.row_err    = row_err_q;

endmodule

// File: tb/tb_pe_window_feeder.sv
// Directed bench for pe_window_feeder with K=3, DATA_W=8, IMG_W=5, IMG_H=2.
// Inputs change 1 time unit after the rising edge; outputs are sampled at the same point.
// Expected windows are written out by hand per scenario.
module tb_pe_window_feeder;

   localparam int K     = 3;
   localparam int DW    = 8;
   localparam int IMG_W = 5;
   localparam int IMG_H = 2;

   logic clk = 1'b0;
   logic rst_n;
   int   n_checks = 0;
   int   n_errors = 0;

   pe_window_feeder_if #(.K(K), .DATA_W(DW)) bus ();

   pe_window_feeder #(
      .K      (K),
      .DATA_W (DW),
      .IMG_W  (IMG_W),
      .IMG_H  (IMG_H)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // Element 0 (oldest) in the low byte.
   function automatic logic [31:0] pack3(input int a, input int b, input int c);
      return {8'h00, c[7:0], b[7:0], a[7:0]};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_idle(input string pfx);
      chk({pfx, "_w_ready"},    32'(bus.w_ready),    1);
      chk({pfx, "_pix_ready"},  32'(bus.pix_ready),  0);
      chk({pfx, "_out_valid"},  32'(bus.out_valid),  0);
      chk({pfx, "_out_data"},   32'(bus.out_data),   0);
      chk({pfx, "_out_weight"}, 32'(bus.out_weight), 0);
      chk({pfx, "_frame_done"}, 32'(bus.frame_done), 0);
      chk({pfx, "_row_err"},    32'(bus.row_err),    0);
   endtask

   task automatic load_w(input int a, input int b, input int c);
      chk("load_w_ready", 32'(bus.w_ready), 1);
      bus.w_data  = 24'(pack3(a, b, c));
      bus.w_valid = 1'b1;
      step();
      bus.w_valid = 1'b0;
      chk("load_out_weight", 32'(bus.out_weight), pack3(a, b, c));
      chk("load_pix_ready",  32'(bus.pix_ready),  1);
      chk("load_w_ready_lo", 32'(bus.w_ready),    0);
      chk("load_row_err",    32'(bus.row_err),    0);
   endtask

   // One accept, then 'gap' idle cycles during which out_valid must stay low.
   task automatic send_pix(input int d, input bit last, input bit exp_v,
                           input logic [31:0] exp_w, input bit exp_fd, input int gap);
      chk("pix_ready", 32'(bus.pix_ready), 1);
      bus.pix_data  = d[7:0];
      bus.pix_last  = last;
      bus.pix_valid = 1'b1;
      step();
      bus.pix_valid = 1'b0;
      bus.pix_last  = 1'b0;
      chk("out_valid", 32'(bus.out_valid), 32'(exp_v));
      if (exp_v) begin
         chk("out_data", 32'(bus.out_data), exp_w);
      end
      chk("frame_done", 32'(bus.frame_done), 32'(exp_fd));
      for (int g = 0; g < gap; g++) begin
         step();
         chk("gap_out_valid",  32'(bus.out_valid),  0);
         chk("gap_frame_done", 32'(bus.frame_done), 0);
      end
   endtask

   task automatic send_row(input int px[5], input bit lst[5], input logic [31:0] ew[3],
                           input int gap, input bit final_row);
      for (int j = 0; j < 5; j++) begin
         send_pix(px[j], lst[j], j >= 2, ew[(j >= 2) ? j - 2 : 0],
                  final_row && (j == 4), gap);
      end
   endtask

   initial begin
      rst_n         = 1'b0;
      bus.w_valid   = 1'b0;
      bus.w_data    = '0;
      bus.pix_valid = 1'b0;
      bus.pix_data  = '0;
      bus.pix_last  = 1'b0;
      repeat (2) step();
      check_idle("por");
      rst_n = 1'b1;
      step();

      // Single row, then frame end; weights offered during RUN must be ignored.
      load_w(1, 2, 3);
      bus.w_valid = 1'b1;
      bus.w_data  = 24'(pack3(9, 9, 9));
      send_row('{10, 20, 30, 40, 50}, '{0, 0, 0, 0, 1},
               '{pack3(10, 20, 30), pack3(20, 30, 40), pack3(30, 40, 50)}, 0, 1'b0);
      bus.w_valid = 1'b0;
      chk("run_w_ignored", 32'(bus.out_weight), pack3(1, 2, 3));
      send_row('{-1, -2, -3, -4, -5}, '{0, 0, 0, 0, 1},
               '{pack3(-1, -2, -3), pack3(-2, -3, -4), pack3(-3, -4, -5)}, 0, 1'b1);
      chk("end_pix_ready", 32'(bus.pix_ready), 0);
      chk("end_w_ready",   32'(bus.w_ready),   1);
      step();
      chk("post_frame_done", 32'(bus.frame_done), 0);
      chk("post_out_valid",  32'(bus.out_valid),  0);
      chk("post_out_data",   32'(bus.out_data),   pack3(-3, -4, -5));
      chk("post_weight",     32'(bus.out_weight), pack3(1, 2, 3));

      // Two idle cycles after every pixel.
      load_w(1, 2, 3);
      send_row('{10, 20, 30, 40, 50}, '{0, 0, 0, 0, 1},
               '{pack3(10, 20, 30), pack3(20, 30, 40), pack3(30, 40, 50)}, 2, 1'b0);
      send_row('{-1, -2, -3, -4, -5}, '{0, 0, 0, 0, 1},
               '{pack3(-1, -2, -3), pack3(-2, -3, -4), pack3(-3, -4, -5)}, 2, 1'b1);
      chk("stall_pix_ready", 32'(bus.pix_ready), 0);
      chk("stall_w_ready",   32'(bus.w_ready),   1);

      // pix_last early on the 3rd pixel and missing on the 5th.
      load_w(7, 8, 9);
      send_pix(1, 1'b0, 1'b0, 0, 1'b0, 0);
      chk("err_c0", 32'(bus.row_err), 0);
      send_pix(2, 1'b0, 1'b0, 0, 1'b0, 0);
      chk("err_c1", 32'(bus.row_err), 0);
      send_pix(3, 1'b1, 1'b1, pack3(1, 2, 3), 1'b0, 0);
      chk("err_c2", 32'(bus.row_err), 1);
      send_pix(4, 1'b0, 1'b1, pack3(2, 3, 4), 1'b0, 0);
      chk("err_c3", 32'(bus.row_err), 1);
      send_pix(5, 1'b0, 1'b1, pack3(3, 4, 5), 1'b0, 0);
      chk("err_c4", 32'(bus.row_err), 1);
      send_row('{6, 7, 8, 9, 10}, '{0, 0, 0, 0, 1},
               '{pack3(6, 7, 8), pack3(7, 8, 9), pack3(8, 9, 10)}, 0, 1'b1);
      chk("err_sticky", 32'(bus.row_err), 1);
      load_w(4, 5, 6);

      // Reset in the middle of a row.
      send_pix(7, 1'b0, 1'b0, 0, 1'b0, 0);
      send_pix(8, 1'b0, 1'b0, 0, 1'b0, 0);
      send_pix(9, 1'b0, 1'b1, pack3(7, 8, 9), 1'b0, 0);
      rst_n = 1'b0;
      #1;
      check_idle("mid_rst");
      step();
      check_idle("mid_rst_edge");
      rst_n = 1'b1;
      step();
      chk("after_rst_out_valid", 32'(bus.out_valid), 0);
      load_w(4, 5, 6);
      send_row('{1, 2, 3, 4, 5}, '{0, 0, 0, 0, 1},
               '{pack3(1, 2, 3), pack3(2, 3, 4), pack3(3, 4, 5)}, 0, 1'b0);
      chk("reload_weight", 32'(bus.out_weight), pack3(4, 5, 6));
      send_row('{11, 12, 13, 14, 15}, '{0, 0, 0, 0, 1},
               '{pack3(11, 12, 13), pack3(12, 13, 14), pack3(13, 14, 15)}, 0, 1'b1);
      chk("reload_end_w_ready", 32'(bus.w_ready), 1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

endmodule
